ld_st_wakeup_queue: RTL and testbench

LD_ST_WAKEUP_QUEUE -- requirements
Module: ld_st_wakeup_queue

---
 rtl/rv32i_types.sv | 25 ++
 rtl/ld_st_wakeup_cmp.sv | 30 +++
 rtl/ld_st_wakeup_queue.sv | 114 +++++++++++
 tb/tb_ld_st_wakeup_queue.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared core types: physical register tags, load/store queue entries and CDB broadcasts.
package rv32i_types;

   localparam int PHYS_REG_W = 6;

   typedef logic [PHYS_REG_W-1:0] phys_reg_t;

   typedef struct packed {
      logic [3:0]  rob_idx;
      logic        is_store;
      logic [2:0]  funct3;
      logic [11:0] imm;
      phys_reg_t   rs1_paddr;
      logic        rs1_rdy;
      phys_reg_t   rs2_paddr;
      logic        rs2_rdy;
      logic        ready;
   } ld_st_data_pkt_t;

   typedef struct packed {
      logic      cdb_broadcast;
      phys_reg_t cdb_p_addr;
   } cdb_pkt_t;

endpackage

// File: rtl/ld_st_wakeup_cmp.sv
// Per-entry source-tag match against every CDB port; returns merged ready bits.
module ld_st_wakeup_cmp
   import rv32i_types::*;
#(
   parameter int NUM_CDB = 2
) (
   input  ld_st_data_pkt_t pkt_in,
   input  cdb_pkt_t        cdb_pkt [NUM_CDB],
   output logic            rs1_rdy,
   output logic            rs2_rdy,
   output logic            ready
);

   logic hit1, hit2;

   always_comb begin
      hit1 = 1'b0;
      hit2 = 1'b0;
      for (int k = 0; k < NUM_CDB; k++) begin
         if (cdb_pkt[k].cdb_broadcast) begin
            if (cdb_pkt[k].cdb_p_addr == pkt_in.rs1_paddr) hit1 = 1'b1;
            if (cdb_pkt[k].cdb_p_addr == pkt_in.rs2_paddr) hit2 = 1'b1;
         end
      end
      rs1_rdy = pkt_in.rs1_rdy | hit1;
      rs2_rdy = pkt_in.rs2_rdy | hit2;
      ready   = rs1_rdy & rs2_rdy;
   end

endmodule

// File: rtl/ld_st_wakeup_queue.sv
// In-order load/store issue FIFO whose entries snoop the CDB for source wakeup.
// Outputs come only from registered state; wakeups show up one cycle after the broadcast.
module ld_st_wakeup_queue
   import rv32i_types::*;
#(
   parameter int DEPTH   = 8,
   parameter int NUM_CDB = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       wen,
   input  ld_st_data_pkt_t            fifo_in,
   input  logic                       ren,
   input  cdb_pkt_t                   cdb_pkt [NUM_CDB],
   output ld_st_data_pkt_t            fifo_out,
   output logic                       fifo_out_valid,
   output logic                       fifo_empty,
   output logic                       fifo_full,
   output logic [$clog2(DEPTH):0]     fifo_count
);

   localparam int IW = $clog2(DEPTH);
   localparam int PW = IW + 1;

   logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
   logic [DEPTH-1:0] valid_q, valid_d;
   ld_st_data_pkt_t entries_q [DEPTH];
   ld_st_data_pkt_t entries_d [DEPTH];

   // Index DEPTH of the comparator array is the enqueue bypass path.
   ld_st_data_pkt_t cmp_in  [DEPTH+1];
   logic            cmp_rs1 [DEPTH+1];
   logic            cmp_rs2 [DEPTH+1];
   logic            cmp_rdy [DEPTH+1];

   logic [IW-1:0] head_idx, tail_idx;
   logic          do_enq, do_deq;

   assign head_idx       = head_q[IW-1:0];
   assign tail_idx       = tail_q[IW-1:0];
   assign fifo_empty     = (head_q == tail_q);
   assign fifo_full      = (head_q[IW] != tail_q[IW]) && (head_idx == tail_idx);
   assign fifo_count     = tail_q - head_q;
   assign fifo_out       = entries_q[head_idx];
   assign fifo_out_valid = !fifo_empty && entries_q[head_idx].ready;

   assign do_enq = wen && !fifo_full && !flush;
   assign do_deq = ren && fifo_out_valid && !flush;

   for (genvar i = 0; i <= DEPTH; i++) begin : g_cmp
      if (i < DEPTH) begin : g_ent
         assign cmp_in[i] = entries_q[i];
      end else begin : g_byp
         assign cmp_in[i] = fifo_in;
      end
      ld_st_wakeup_cmp #(.NUM_CDB(NUM_CDB)) u_cmp (
         .pkt_in  (cmp_in[i]),
         .cdb_pkt (cdb_pkt),
         .rs1_rdy (cmp_rs1[i]),
         .rs2_rdy (cmp_rs2[i]),
         .ready   (cmp_rdy[i])
      );
   end

   always_comb begin
      head_d    = head_q;
      tail_d    = tail_q;
      valid_d   = valid_q;
      entries_d = entries_q;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid_q[i]) begin
            entries_d[i].rs1_rdy = cmp_rs1[i];
            entries_d[i].rs2_rdy = cmp_rs2[i];
            entries_d[i].ready   = cmp_rdy[i];
         end
      end
      if (do_deq) begin
         valid_d[head_idx] = 1'b0;
         head_d            = head_q + 1'b1;
      end
      if (do_enq) begin
         entries_d[tail_idx]         = fifo_in;
         entries_d[tail_idx].rs1_rdy = cmp_rs1[DEPTH];
         entries_d[tail_idx].rs2_rdy = cmp_rs2[DEPTH];
         entries_d[tail_idx].ready   = cmp_rdy[DEPTH];
         valid_d[tail_idx]           = 1'b1;
         tail_d                      = tail_q + 1'b1;
      end
      if (flush) begin
         valid_d = '0;
         head_d  = '0;
         tail_d  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         valid_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         valid_q <= valid_d;
      end
   end

   // Payloads carry no reset; valid bits alone decide what is live.
   always_ff @(posedge clk) begin
      entries_q <= entries_d;
   end

endmodule

// File: tb/tb_ld_st_wakeup_queue.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based model.
module tb_ld_st_wakeup_queue;
   import rv32i_types::*;

   localparam int DEPTH = 4;
   localparam int NCDB  = 2;

   logic            clk = 1'b0;
   logic            rst = 1'b0, flush = 1'b0, wen = 1'b0, ren = 1'b0;
   ld_st_data_pkt_t fifo_in = '0;
   cdb_pkt_t        cdb [NCDB];
   ld_st_data_pkt_t fifo_out;
   logic            fifo_out_valid, fifo_empty, fifo_full;
   logic [2:0]      fifo_count;

   int checks = 0, errors = 0;
   ld_st_data_pkt_t mq[$];
   int tag_ctr = 1;

   always #5 clk = ~clk;

   ld_st_wakeup_queue #(.DEPTH(DEPTH), .NUM_CDB(NCDB)) dut (
      .clk(clk), .rst(rst), .flush(flush), .wen(wen), .fifo_in(fifo_in), .ren(ren),
      .cdb_pkt(cdb), .fifo_out(fifo_out), .fifo_out_valid(fifo_out_valid),
      .fifo_empty(fifo_empty), .fifo_full(fifo_full), .fifo_count(fifo_count)
   );

   function automatic ld_st_data_pkt_t mk(int tag, int a1, bit r1, int a2, bit r2, bit rdy_in);
      ld_st_data_pkt_t p;
      p = '0;
      p.rob_idx   = 4'(tag);
      p.imm       = 12'(tag);
      p.is_store  = tag[0];
      p.funct3    = 3'(tag);
      p.rs1_paddr = PHYS_REG_W'(a1);
      p.rs1_rdy   = r1;
      p.rs2_paddr = PHYS_REG_W'(a2);
      p.rs2_rdy   = r2;
      p.ready     = rdy_in;
      return p;
   endfunction

   // Model: a source is ready if it already was, or any broadcasting port names its tag.
   function automatic ld_st_data_pkt_t wake(ld_st_data_pkt_t p);
      ld_st_data_pkt_t q;
      q = p;
      for (int k = 0; k < NCDB; k++) begin
         if (cdb[k].cdb_broadcast && cdb[k].cdb_p_addr == p.rs1_paddr) q.rs1_rdy = 1'b1;
         if (cdb[k].cdb_broadcast && cdb[k].cdb_p_addr == p.rs2_paddr) q.rs2_rdy = 1'b1;
      end
      q.ready = q.rs1_rdy && q.rs2_rdy;
      return q;
   endfunction

   function automatic void bcast(int port, int addr);
      cdb[port].cdb_broadcast = 1'b1;
      cdb[port].cdb_p_addr    = PHYS_REG_W'(addr);
   endfunction

   task automatic cycle(input bit w, input ld_st_data_pkt_t p, input bit r, input bit f, input bit rs);
      bit ov, enq, deq;
      wen = w; fifo_in = p; ren = r; flush = f; rst = rs;
      ov = mq.size() > 0 && mq[0].ready;
      if (rs || f) mq.delete();
      else begin
         enq = w && mq.size() < DEPTH;
         deq = r && ov;
         foreach (mq[i]) mq[i] = wake(mq[i]);
         if (deq) void'(mq.pop_front());
         if (enq) mq.push_back(wake(p));
      end
      @(posedge clk); #1;
      wen = 0; ren = 0; flush = 0; rst = 0;
      for (int k = 0; k < NCDB; k++) cdb[k] = '0;
   endtask

   task automatic do_reset();
      cycle(0, '0, 0, 0, 1);
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", fifo_empty); end
      checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", fifo_full); end
      checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
      checks++; if (fifo_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", fifo_out_valid); end
   endtask

   task automatic test_fill();
      do_reset();
      for (int i = 0; i < 4; i++) cycle(1, mk(10 + i, 1, 1, 2, 1, 1), 0, 0, 0);
      checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL fill_full got=%b exp=1", fifo_full); end
      checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL fill_count got=%0d exp=4", fifo_count); end
      cycle(1, mk(99, 1, 1, 2, 1, 1), 0, 0, 0);
      checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL fill_drop5 got=%0d exp=4", fifo_count); end
      // wen while full is dropped even with a same-cycle dequeue
      cycle(1, mk(98, 1, 1, 2, 1, 1), 1, 0, 0);
      checks++; if (fifo_count !== 3'd3) begin errors++; $display("FAIL fill_nopass got=%0d exp=3", fifo_count); end
      for (int i = 1; i < 4; i++) begin
         checks++;
         if (fifo_out.imm !== 12'(10 + i)) begin errors++; $display("FAIL fill_order got=%0d exp=%0d", fifo_out.imm, 10 + i); end
         cycle(0, '0, 1, 0, 0);
      end
      checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL fill_empty got=%b exp=1", fifo_empty); end
   endtask

   task automatic test_wakeup();
      do_reset();
      cycle(1, mk(20, 5, 0, 6, 1, 0), 0, 0, 0);
      checks++; if (fifo_out_valid !== 1'b0) begin errors++; $display("FAIL wake_notready got=%b exp=0", fifo_out_valid); end
      cycle(0, '0, 1, 0, 0);
      checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL wake_ren_ignored got=%0d exp=1", fifo_count); end
      bcast(1, 5);
      cycle(0, '0, 1, 0, 0);
      checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL wake_ren_samecyc got=%0d exp=1", fifo_count); end
      checks++; if (fifo_out_valid !== 1'b1) begin errors++; $display("FAIL wake_valid got=%b exp=1", fifo_out_valid); end
      cycle(0, '0, 1, 0, 0);
      checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL wake_deq got=%b exp=1", fifo_empty); end
   endtask

   task automatic test_bypass();
      do_reset();
      bcast(0, 7);
      cycle(1, mk(30, 7, 0, 8, 0, 1), 0, 0, 0);
      checks++; if (fifo_out.rs1_rdy !== 1'b1) begin errors++; $display("FAIL bypass_rs1 got=%b exp=1", fifo_out.rs1_rdy); end
      checks++; if (fifo_out.ready !== 1'b0) begin errors++; $display("FAIL bypass_ready got=%b exp=0", fifo_out.ready); end
   endtask

   task automatic test_dual();
      do_reset();
      cycle(1, mk(40, 3, 0, 9, 0, 0), 0, 0, 0);
      bcast(0, 3); bcast(1, 9);
      cycle(0, '0, 0, 0, 0);
      checks++; if (fifo_out.ready !== 1'b1) begin errors++; $display("FAIL dual_ready got=%b exp=1", fifo_out.ready); end
      checks++; if (fifo_out_valid !== 1'b1) begin errors++; $display("FAIL dual_valid got=%b exp=1", fifo_out_valid); end
   endtask

   task automatic test_wrap();
      do_reset();
      cycle(1, mk(50, 1, 1, 1, 1, 1), 0, 0, 0);
      cycle(1, mk(51, 1, 1, 1, 1, 1), 0, 0, 0);
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (fifo_out.imm !== 12'(50 + i)) begin errors++; $display("FAIL wrap_order got=%0d exp=%0d", fifo_out.imm, 50 + i); end
         cycle(1, mk(52 + i, 1, 1, 1, 1, 1), 1, 0, 0);
         checks++;
         if (fifo_count !== 3'd2) begin errors++; $display("FAIL wrap_count got=%0d exp=2", fifo_count); end
      end
   endtask

   task automatic test_flush_reset();
      do_reset();
      for (int i = 0; i < 3; i++) cycle(1, mk(60 + i, 1, 1, 1, 1, 1), 0, 0, 0);
      cycle(1, mk(70, 1, 1, 1, 1, 1), 1, 1, 0);
      checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL flush_empty got=%b exp=1", fifo_empty); end
      checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL flush_count got=%0d exp=0", fifo_count); end
      for (int i = 0; i < 4; i++) cycle(1, mk(80 + i, 1, 1, 1, 1, 1), 0, 0, 0);
      cycle(1, mk(90, 1, 1, 1, 1, 1), 1, 1, 1);
      checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL rst_empty got=%b exp=1", fifo_empty); end
      checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL rst_count got=%0d exp=0", fifo_count); end
      checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL rst_full got=%b exp=0", fifo_full); end
   endtask

   task automatic test_random();
      bit w, r, f, rs;
      ld_st_data_pkt_t p;
      do_reset();
      for (int n = 0; n < 400; n++) begin
         p = mk(tag_ctr, $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7),
                $urandom_range(0, 1), $urandom_range(0, 1));
         tag_ctr++;
         w  = $urandom_range(0, 99) < 55;
         r  = $urandom_range(0, 99) < 50;
         f  = $urandom_range(0, 49) == 0;
         rs = $urandom_range(0, 99) == 0;
         for (int k = 0; k < NCDB; k++)
            if ($urandom_range(0, 2) == 0) bcast(k, $urandom_range(0, 7));
         cycle(w, p, r, f, rs);
         checks++;
         if (fifo_count !== 3'(mq.size())) begin errors++; $display("FAIL rnd_count n=%0d got=%0d exp=%0d", n, fifo_count, mq.size()); end
         checks++;
         if (fifo_empty !== (mq.size() == 0) || fifo_full !== (mq.size() == DEPTH)) begin
            errors++; $display("FAIL rnd_flags n=%0d got=%b%b exp=%b%b", n, fifo_empty, fifo_full, mq.size() == 0, mq.size() == DEPTH);
         end
         if (mq.size() > 0) begin
            checks++;
            if (fifo_out !== mq[0]) begin errors++; $display("FAIL rnd_out n=%0d got=%h exp=%h", n, fifo_out, mq[0]); end
            checks++;
            if (fifo_out_valid !== mq[0].ready) begin errors++; $display("FAIL rnd_valid n=%0d got=%b exp=%b", n, fifo_out_valid, mq[0].ready); end
         end
      end
   endtask

   initial begin
      for (int k = 0; k < NCDB; k++) cdb[k] = '0;
      #2;
      test_reset();
      test_fill();
      test_wakeup();
      test_bypass();
      test_dual();
      test_wrap();
      test_flush_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
